// File: rtl/free_list_if.sv
`default_nettype none
// ============================================================================
// Module   : free_list_if
// Purpose  : Rename-stage bundle between the dispatch/retire logic and the
//            physical register free list.
// Ports    : master - dispatch/retire side: drives requests, retiring T_old
//                     tags and the flush; observes offered tags and occupancy.
//            slave  - free list side: the mirror image of master.
// Revision : 1.0 - initial release
// ============================================================================
interface free_list_if #(
  parameter int SS_SIZE      = 2,
  parameter int NUM_PHYS_REG = 64,
  parameter int NUM_ARCH_REG = 32
);
  localparam int TW      = $clog2(NUM_PHYS_REG);
  localparam int FL_SIZE = NUM_PHYS_REG - NUM_ARCH_REG;
  localparam int CW      = $clog2(FL_SIZE) + 1;

  // Lane SS_SIZE-1 is the oldest lane on every vector below.
  logic [SS_SIZE-1:0]         dispatch_en;
  logic [SS_SIZE-1:0]         retire_en;
  logic [SS_SIZE-1:0]         retire_alloc;
  logic [SS_SIZE-1:0][TW-1:0] T_old_in;
  logic                       branch_not_taken;
  logic [SS_SIZE-1:0][TW-1:0] free_reg;
  logic [SS_SIZE-1:0]         free_valid;
  logic [CW-1:0]              num_free;
  logic                       empty;

  modport master (
    output dispatch_en, retire_en, retire_alloc, T_old_in, branch_not_taken,
    input  free_reg, free_valid, num_free, empty
  );

  modport slave (
    input  dispatch_en, retire_en, retire_alloc, T_old_in, branch_not_taken,
    output free_reg, free_valid, num_free, empty
  );
endinterface
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Circular FIFO of free physical register tags for an R10K-style
//            rename pipeline. Offers one tag per dispatch lane, reclaims the
//            T_old of every retiring entry that allocated a destination, and
//            recovers all speculative allocations in one cycle on a flush by
//            snapping the head back to the committed head.
// Ports    : clock - rising-edge clock
//            reset - asynchronous, active-low reset
//            fl    - free_list_if slave modport:
//                    in : dispatch_en, retire_en, retire_alloc, T_old_in,
//                         branch_not_taken
//                    out: free_reg, free_valid, num_free, empty
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
  parameter int SS_SIZE      = 2,
  parameter int NUM_PHYS_REG = 64,
  parameter int NUM_ARCH_REG = 32
) (
  input  logic       clock,
  input  logic       reset,
  free_list_if.slave fl
);

  localparam int TW      = $clog2(NUM_PHYS_REG);
  localparam int FL_SIZE = NUM_PHYS_REG - NUM_ARCH_REG;
  // Pointer width; kept at least one bit so a degenerate one-entry list
  // still elaborates.
  localparam int PW      = (FL_SIZE > 1) ? $clog2(FL_SIZE) : 1;
  localparam int CW      = $clog2(FL_SIZE) + 1;

  localparam logic [PW+1:0] FL_SIZE_S = (PW+2)'(FL_SIZE);
  localparam logic [CW-1:0] FL_SIZE_C = CW'(FL_SIZE);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TW-1:0] mem_q [FL_SIZE];
  logic [TW-1:0] mem_d [FL_SIZE];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] commit_head_q, commit_head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  // Free-entry count at the committed point. Allocation and reclamation
  // always balance there, so it holds its reset value and is what the count
  // snaps back to on a flush.
  logic [CW-1:0] commit_count_q, commit_count_d;

  logic [SS_SIZE-1:0][TW-1:0] offer_reg;
  logic [SS_SIZE-1:0]         offer_valid;
  logic [CW-1:0]              n_alloc;
  logic [CW-1:0]              n_free;

  // Modular pointer advance. FL_SIZE need not be a power of two, so the sum
  // is formed two bits wider and folded once with compare-and-subtract; the
  // step never exceeds FL_SIZE so a single fold is sufficient.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p,
                                             input logic [CW-1:0] n);
    logic [PW+1:0] s;
    s = (PW+2)'(p) + (PW+2)'(n);
    if (s >= FL_SIZE_S) begin
      s = s - FL_SIZE_S;
    end
    return s[PW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Offer: the oldest lane sees the entry at head, younger lanes the entries
  // behind it. A lane is granted only while enough entries remain, so tags
  // reclaimed this cycle are never bypassed into the offer.
  // --------------------------------------------------------------------------
  always_comb begin
    offer_reg   = '0;
    offer_valid = '0;
    for (int k = 0; k < SS_SIZE; k++) begin
      offer_reg[SS_SIZE-1-k]   = mem_q[wrap_add(head_q, CW'(k))];
      offer_valid[SS_SIZE-1-k] = (CW'(k) < count_q);
    end
  end

  assign fl.free_reg   = offer_reg;
  assign fl.free_valid = offer_valid;
  assign fl.num_free   = count_q;
  assign fl.empty      = (count_q == '0);

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d          = mem_q;
    head_d         = head_q;
    commit_head_d  = commit_head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_count_d = commit_count_q;
    n_alloc        = '0;
    n_free         = '0;

    // Reclaim: walk lanes oldest first so T_old tags land in retire order.
    // Lanes whose entry had no destination are skipped without leaving a gap.
    for (int l = SS_SIZE - 1; l >= 0; l--) begin
      if (fl.retire_en[l] && fl.retire_alloc[l]) begin
        mem_d[wrap_add(tail_q, n_free)] = fl.T_old_in[l];
        n_free = n_free + CW'(1);
      end
    end

    // Grants are contiguous from the oldest lane, so the number of tags
    // taken is simply the number of requesting lanes that were offered one.
    for (int l = 0; l < SS_SIZE; l++) begin
      if (fl.dispatch_en[l] && offer_valid[l]) begin
        n_alloc = n_alloc + CW'(1);
      end
    end

    // Every retiring allocator consumed exactly one in-order allocation, so
    // the committed head advances by the same amount as the tail.
    tail_d        = wrap_add(tail_q, n_free);
    commit_head_d = wrap_add(commit_head_q, n_free);

    if (fl.branch_not_taken) begin
      // Retirement in this cycle is kept; every speculative allocation is
      // returned by rewinding head to the updated committed head, and this
      // cycle's dispatch is dropped.
      head_d  = commit_head_d;
      count_d = commit_count_q;
    end else begin
      head_d  = wrap_add(head_q, n_alloc);
      count_d = count_q - n_alloc + n_free;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        mem_q[i] <= TW'(NUM_ARCH_REG + i);
      end
      head_q         <= '0;
      commit_head_q  <= '0;
      tail_q         <= '0;
      count_q        <= FL_SIZE_C;
      commit_count_q <= FL_SIZE_C;
    end else begin
      mem_q          <= mem_d;
      head_q         <= head_d;
      commit_head_q  <= commit_head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_count_q <= commit_count_d;
    end
  end

`ifndef SYNTHESIS
  // --------------------------------------------------------------------------
  // Simulation-only protocol checks
  // --------------------------------------------------------------------------
  function automatic logic contiguous_from_msb(input logic [SS_SIZE-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < SS_SIZE - 1; i++) begin
      if (v[i] && !v[i+1]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Allocations handed out but not yet retired; a flush squashes them all.
  logic [CW:0] live_alloc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live_alloc_q <= '0;
    end else if (fl.branch_not_taken) begin
      live_alloc_q <= '0;
    end else begin
      live_alloc_q <= live_alloc_q + (CW+1)'(n_alloc) - (CW+1)'(n_free);
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      assert ((CW+1)'(count_q) + (CW+1)'(n_free) <= (CW+1)'(FL_SIZE))
        else $error("free_list: reclaim would overflow the list");
      assert ((CW+1)'(n_free) <= live_alloc_q)
        else $error("free_list: retire_alloc without a prior allocation");
      assert (contiguous_from_msb(fl.dispatch_en))
        else $error("free_list: dispatch_en not contiguous from MSB");
      assert (contiguous_from_msb(fl.retire_en))
        else $error("free_list: retire_en not contiguous from MSB");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Purpose  : Self-checking bench for free_list: a table of directed
//            single-cycle vectors followed by hand-written drain, empty-list
//            reclaim and asynchronous mid-run reset sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;

  localparam int SS_SIZE      = 2;
  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_ARCH_REG = 32;

  logic clock;
  logic reset;

  int checks   = 0;
  int failures = 0;

  free_list_if #(
    .SS_SIZE      (SS_SIZE),
    .NUM_PHYS_REG (NUM_PHYS_REG),
    .NUM_ARCH_REG (NUM_ARCH_REG)
  ) fl_if ();

  free_list #(
    .SS_SIZE      (SS_SIZE),
    .NUM_PHYS_REG (NUM_PHYS_REG),
    .NUM_ARCH_REG (NUM_ARCH_REG)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] disp;
    logic [1:0] ren;
    logic [1:0] ralloc;
    logic [5:0] t1;
    logic [5:0] t0;
    logic       bnt;
    int         e_fr1;
    int         e_fr0;
    logic [1:0] e_valid;
    int         e_nf;
    logic       e_empty;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int fr1, input int fr0,
                           input int valid, input int nf, input int emp);
    check({tag, ".free_reg1"},  int'(fl_if.free_reg[1]), fr1);
    check({tag, ".free_reg0"},  int'(fl_if.free_reg[0]), fr0);
    check({tag, ".free_valid"}, int'(fl_if.free_valid),  valid);
    check({tag, ".num_free"},   int'(fl_if.num_free),    nf);
    check({tag, ".empty"},      int'(fl_if.empty),       emp);
  endtask

  task automatic drive(input logic [1:0] disp, input logic [1:0] ren,
                       input logic [1:0] ralloc, input logic [5:0] t1,
                       input logic [5:0] t0, input logic bnt);
    fl_if.dispatch_en      = disp;
    fl_if.retire_en        = ren;
    fl_if.retire_alloc     = ralloc;
    fl_if.T_old_in[1]      = t1;
    fl_if.T_old_in[0]      = t0;
    fl_if.branch_not_taken = bnt;
  endtask

  // Apply the driven inputs across one rising edge, then settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Tags are hand-traced from reset: mem[i]=32+i, head=tail=0.
    vecs[0] = '{2'b11, 2'b00, 2'b00, 6'd0,  6'd0,  1'b0, 34, 35, 2'b11, 30, 1'b0};
    vecs[1] = '{2'b10, 2'b00, 2'b00, 6'd0,  6'd0,  1'b0, 35, 36, 2'b11, 29, 1'b0};
    // Reclaim 3,4 into mem[0],mem[1]; committed head moves to 2.
    vecs[2] = '{2'b00, 2'b11, 2'b11, 6'd3,  6'd4,  1'b0, 35, 36, 2'b11, 31, 1'b0};
    // Flush: head back to 2, list is 34..63,3,4, dispatch ignored.
    vecs[3] = '{2'b11, 2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 34, 35, 2'b11, 32, 1'b0};
    vecs[4] = '{2'b11, 2'b00, 2'b00, 6'd0,  6'd0,  1'b0, 36, 37, 2'b11, 30, 1'b0};
    // Mixed lanes: only lane 1 frees (9 into mem[2]); one lane dispatches.
    vecs[5] = '{2'b10, 2'b11, 2'b10, 6'd9,  6'd20, 1'b0, 37, 38, 2'b11, 30, 1'b0};
    // Flush with a same-cycle reclaim of 11: head = old commit_head+1 = 4.
    vecs[6] = '{2'b11, 2'b10, 2'b10, 6'd11, 6'd0,  1'b1, 36, 37, 2'b11, 32, 1'b0};

    reset = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_all("reset", 32, 33, 2'b11, 32, 0);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].disp, vecs[i].ren, vecs[i].ralloc,
            vecs[i].t1, vecs[i].t0, vecs[i].bnt);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_fr1, vecs[i].e_fr0,
                int'(vecs[i].e_valid), vecs[i].e_nf, int'(vecs[i].e_empty));
    end

    // Drain two per cycle from 32 free entries; head wraps from 4 to 2.
    for (int c = 1; c <= 15; c++) begin
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      step();
      check($sformatf("drain%0d.num_free", c), int'(fl_if.num_free), 32 - 2 * c);
    end
    check_all("drain_tail", 9, 11, 2'b11, 2, 0);

    // One entry left: only the oldest lane is granted.
    drive(2'b10, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    step();
    check("one_left.free_reg1",  int'(fl_if.free_reg[1]), 11);
    check("one_left.free_valid", int'(fl_if.free_valid),  2'b10);
    check("one_left.num_free",   int'(fl_if.num_free),    1);

    // Both lanes ask but only lane 1 has a grant.
    drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    step();
    check("empty.free_valid", int'(fl_if.free_valid), 2'b00);
    check("empty.num_free",   int'(fl_if.num_free),   0);
    check("empty.empty",      int'(fl_if.empty),      1);

    // Reclaim 5,7 into an empty list while dispatch is requested: no bypass,
    // the tags appear next cycle.
    drive(2'b11, 2'b11, 2'b11, 6'd5, 6'd7, 1'b0);
    #1;
    check("no_bypass.free_valid", int'(fl_if.free_valid), 2'b00);
    step();
    check_all("refill", 5, 7, 2'b11, 2, 0);

    // Asynchronous reset between clock edges.
    drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check_all("async_reset", 32, 33, 2'b11, 32, 0);
    #1;
    reset = 1'b1;
    step();
    check_all("post_reset", 32, 33, 2'b11, 32, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register tags for the R10K-style rename pipeline.
- Sits directly upstream of the ROB: it supplies T_new for each dispatching lane.
- It consumes the ROB retire output and reclaims T_old for every retiring entry that allocated a destination.
- A committed-head pointer gives single-cycle recovery on branch_not_taken; all speculatively allocated tags return to the list.

Parameters:
SS_SIZE, 2, superscalar width (dispatch and retire lanes)
NUM_PHYS_REG, 64, physical register count; tag width TW = $clog2(NUM_PHYS_REG)
NUM_ARCH_REG, 32, architectural register count; FL_SIZE = NUM_PHYS_REG - NUM_ARCH_REG entries

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
dispatch_en  in  SS_SIZE  lane requests a destination tag; lane SS_SIZE-1 is oldest; set bits contiguous from MSB
retire_en  in  SS_SIZE  lane retires this cycle (from ROB retire_out); contiguous from MSB
retire_alloc  in  SS_SIZE  retiring entry had allocated T_new (has a destination)
T_old_in  in  SS_SIZE x TW  T_old of the retiring entry, pushed to the tail
branch_not_taken  in  1  flush: restore head to committed head
free_reg  out  SS_SIZE x TW  tag offered to each lane
free_valid  out  SS_SIZE  tag for the lane is available (combinational grant)
num_free  out  $clog2(FL_SIZE)+1  entries currently in list (registered count)
empty  out  1  num_free == 0

Behaviour:
- State: mem[FL_SIZE] of TW; head, commit_head, tail as $clog2(FL_SIZE)-bit pointers with wrap; count and commit_count registers.
- Reset (reset==0, asynchronous): mem[i] = NUM_ARCH_REG+i. head = commit_head = tail = 0. count = commit_count = FL_SIZE. Outputs settle to num_free=FL_SIZE, empty=0, free_reg[SS_SIZE-1-k]=NUM_ARCH_REG+k, free_valid all 1 (for FL_SIZE>=SS_SIZE).
- Offer (combinational):
  - free_reg[SS_SIZE-1-k] = mem[(head+k) mod FL_SIZE].
  - free_valid[SS_SIZE-1-k] = (k < count).
  - No bypass of tags freed in the same cycle.
- Allocation: n_alloc = number of lanes with dispatch_en & free_valid. Dispatch_en on a lane with free_valid=0 is ignored; the upstream stalls. head += n_alloc mod FL_SIZE.
- Retire/free: n_free = number of lanes with retire_en & retire_alloc. Those T_old_in are written at tail, tail+1, ..., oldest lane (MSB) first. tail += n_free. Lanes without retire_alloc write nothing.
- Commit tracking: commit_head += n_free. Each retiring allocator consumed exactly one in-order allocation, so commit_head tracks the oldest unretired allocation.
- count_next = count - n_alloc + n_free. commit_count_next = commit_count + n_free - n_free = commit_count. Both remain FL_SIZE-consistent: commit_count stays FL_SIZE minus live unretired allocations at the last flush point, and it is only meaningful for recovery.
- Flush (branch_not_taken=1):
  - Retire in the same cycle is applied first (tail and commit_head advance).
  - Then head_next = commit_head_next and count_next = FL_SIZE.
  - Dispatch in that cycle is dropped.
- Simultaneous dispatch and retire with count==0: free_valid=0 this cycle; freed tags are offered next cycle.
- Wrap: all pointer arithmetic is mod FL_SIZE. FL_SIZE need not be a power of two; use compare-and-subtract.
- Assertions (sim only):
  - count + n_free <= FL_SIZE.
  - No retire_alloc without a prior allocation.
  - dispatch_en and retire_en bits contiguous from MSB.
- Reset mid-operation: asynchronous; all state returns to reset values regardless of in-flight handshakes.

Test Plan:
- Reset release, no requests -> free_reg[1]=32, free_reg[0]=33, free_valid=2'b11, num_free=32.
- dispatch_en=2'b11 for 1 cycle -> next cycle free_reg[1]=34, free_reg[0]=35, num_free=30.
- Drain: dispatch 2/cycle for 16 cycles -> num_free=0, empty=1, free_valid=00. Then retire_en=retire_alloc=2'b11, T_old_in={5,7} -> next cycle free_reg[1]=5, free_reg[0]=7, num_free=2.
- Mixed lanes: retire_en=11, retire_alloc=10, T_old_in[1]=9 -> only 9 pushed, num_free +1. Same-cycle dispatch_en=10 -> num_free net unchanged.
- Recovery: from reset, allocate 6 (tags 32..37), retire 2 allocators (T_old 3,4), assert branch_not_taken -> next cycle free_reg[1]=34, num_free=32, and list order is 34..63,3,4.
- Flush with same-cycle retire (1 allocator, T_old 11) and dispatch_en=11 -> dispatch ignored, head = old commit_head+1, 11 appended at tail.
